uart_frame_parser: RTL and testbench

// Downstream consumer of the UART RX byte FIFO (Fifo_UART, legacy read mode). Pops received bytes,

---
 rtl/uart_frame_parser.sv | 133 +++++++++++++
 tb/tb_uart_frame_parser.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Pops bytes from the UART RX FIFO, extracts [SOF][LEN][PAYLOAD][CHK] frames and streams
// payload bytes to the core over valid/ready, reporting per-frame status and statistics.
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_len,
  output logic [15:0] ok_cnt,
  output logic [7:0]  err_cnt
);

  // A zero timeout selects a 1 ms inter-byte limit derived from the clock frequency.
  localparam int unsigned TIMEOUT_EFF = (TIMEOUT_CYC != 0) ? TIMEOUT_CYC : (CLK_FREQ / 1000);
  localparam int unsigned TW          = $clog2(TIMEOUT_EFF + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  state_t        state;
  logic          byte_pend;
  logic [7:0]    sum;
  logic [7:0]    remaining;
  logic [TW-1:0] to_cnt;
  logic          handshake_c;
  logic          timeout_c;

  assign handshake_c = out_valid && out_ready;
  assign fifo_rdreq  = !fifo_empty && !byte_pend && !(out_valid && !out_ready);
  assign timeout_c   = (state != ST_HUNT) && !byte_pend && !out_valid &&
                       (to_cnt == TW'(TIMEOUT_EFF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      byte_pend <= 1'b0;
      sum       <= 8'd0;
      remaining <= 8'd0;
      to_cnt    <= '0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      frame_len <= 8'd0;
      ok_cnt    <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      byte_pend <= fifo_rdreq;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (handshake_c) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      // Inter-byte idle timer; core backpressure (out_valid high) does not age the frame.
      if (byte_pend || state == ST_HUNT) begin
        to_cnt <= '0;
      end else if (!out_valid) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (byte_pend) begin
        case (state)
          ST_HUNT: begin
            if (fifo_q == SOF_BYTE) state <= ST_LEN;
          end
          ST_LEN: begin
            if (fifo_q != SOF_BYTE) begin
              frame_len <= fifo_q;
              if (fifo_q == 8'd0 || 32'(fifo_q) > MAX_LEN) begin
                frame_err <= 1'b1;
                err_code  <= 2'd1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                state     <= ST_HUNT;
              end else begin
                sum       <= fifo_q;
                remaining <= fifo_q;
                state     <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            out_data  <= fifo_q;
            out_valid <= 1'b1;
            out_last  <= (remaining == 8'd1);
            sum       <= sum + fifo_q;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ST_CHK;
          end
          ST_CHK: begin
            if (fifo_q == sum) begin
              frame_ok <= 1'b1;
              if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (timeout_c) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        state     <= ST_HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized frame traffic against a frame-level expectation model (payload and event queues),
// plus directed scenarios with hand-computed results.
module tb_uart_frame_parser;

  localparam logic [7:0]  SOF = 8'hA5;
  localparam int unsigned MAXL = 64;
  localparam int unsigned TO   = 300;

  typedef struct packed {
    logic        ok;
    logic [1:0]  code;
    logic [7:0]  len;
    logic [15:0] okc;
    logic [7:0]  errc;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  frame_len;
  logic [15:0] ok_cnt;
  logic [7:0]  err_cnt;

  int vecs = 0;
  int errs = 0;

  logic [7:0] fifo_mem[$];
  logic [8:0] exp_pay[$];
  evt_t       exp_evt[$];
  logic [15:0] ok_m = 16'd0;
  logic [7:0]  err_m = 8'd0;
  logic [1:0]  code_m = 2'd0;

  int ready_mode = 0;
  int gate_mode  = 0;
  int hold_cnt   = 0;

  uart_frame_parser #(
    .CLK_FREQ(50000000), .SOF_BYTE(SOF), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vecs++;
    errs++;
    $display("FAIL %s", name);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem.push_back(b);
  endtask

  task automatic expect_evt(input logic ok, input logic [1:0] code, input logic [7:0] len);
    evt_t e;
    if (ok) begin
      if (ok_m != 16'hFFFF) ok_m = ok_m + 16'd1;
    end else begin
      if (err_m != 8'hFF) err_m = err_m + 8'd1;
      code_m = code;
    end
    e.ok = ok; e.code = code_m; e.len = len; e.okc = ok_m; e.errc = err_m;
    exp_evt.push_back(e);
  endtask

  // One random frame: optional garbage, 1-2 SOFs, then bad LEN, bad checksum or a good frame.
  task automatic gen_frame();
    int n, kind;
    logic [7:0] len, b, sum;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == SOF);
      push(b);
    end
    n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) push(SOF);
    kind = $urandom_range(0, 7);
    if (kind == 0) begin
      do len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
      while (len == SOF);
      push(len);
      expect_evt(1'b0, 2'd1, len);
    end else begin
      len = 8'($urandom_range(1, MAXL));
      push(len);
      sum = len;
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        push(b);
        exp_pay.push_back({1'(i == int'(len) - 1), b});
        sum = sum + b;
      end
      if (kind == 1) begin
        push(sum ^ 8'($urandom_range(1, 255)));
        expect_evt(1'b0, 2'd2, len);
      end else begin
        push(sum);
        expect_evt(1'b1, 2'd0, len);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((fifo_mem.size() != 0 || exp_pay.size() != 0 || exp_evt.size() != 0 || out_valid)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_now("idle_wait_expired");
    repeat (4) @(negedge clk);
  endtask

  task automatic push_frame1();
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    exp_pay.push_back(9'h011); exp_pay.push_back(9'h022); exp_pay.push_back(9'h133);
    expect_evt(1'b1, 2'd0, 8'd3);
  endtask

  // FIFO model: legacy read mode, data appears the cycle after the pop request.
  always @(posedge clk) begin
    if (rst_n && fifo_rdreq) begin
      if (fifo_mem.size() == 0) fail_now("fifo_underflow");
      else fifo_q <= fifo_mem.pop_front();
    end
  end

  logic       prev_rd = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = 9'd0;
  int         idle_cnt = 0;

  // Drive inputs on the falling edge, then check outputs once they have settled.
  always @(negedge clk) begin
    evt_t e;
    logic [8:0] w;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (!out_valid) begin
          hold_cnt  = 0;
          out_ready = 1'b0;
        end else begin
          hold_cnt++;
          out_ready = (hold_cnt >= 100);
        end
      end
    endcase
    fifo_empty = ((gate_mode != 0) && ($urandom_range(0, 3) == 0)) || (fifo_mem.size() == 0);
    #1;
    if (!rst_n) begin
      prev_rd = 1'b0; prev_stall = 1'b0; idle_cnt = 0;
    end else begin
      if (fifo_rdreq && fifo_empty) fail_now("rdreq_while_empty");
      if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
      if (out_valid && !out_ready) check("stall_rdreq", 32'(fifo_rdreq), 32'd0);
      if (frame_ok && frame_err) fail_now("ok_and_err_together");
      if (out_valid && out_ready) begin
        if (exp_pay.size() == 0) fail_now("unexpected_payload");
        else begin
          w = exp_pay.pop_front();
          check("payload", {out_last, out_data}, w);
        end
      end
      if (frame_ok || frame_err) begin
        if (exp_evt.size() == 0) fail_now("unexpected_frame_event");
        else begin
          e = exp_evt.pop_front();
          check("evt_kind", {frame_ok, frame_err}, {e.ok, !e.ok});
          check("evt_code", err_code, e.code);
          check("evt_len", frame_len, e.len);
          check("evt_ok_cnt", ok_cnt, e.okc);
          check("evt_err_cnt", err_cnt, e.errc);
          if (frame_err && err_code == 2'd3) check("timeout_cycles", idle_cnt, TO);
        end
      end
      if (prev_rd) idle_cnt = 0;
      else if (!out_valid && !frame_err) idle_cnt++;
      prev_rd    = fifo_rdreq;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    #2;
    check("rst_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, frame_len}, 0);
    check("rst_counters", {ok_cnt, err_cnt}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic good frame.
    push_frame1();
    wait_idle(200);
    check("t1_ok_cnt", ok_cnt, 16'd1);
    check("t1_err_cnt", err_cnt, 8'd0);

    // Garbage then checksum failure: 02+AA+BB=67 vs 00.
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h02); push(8'hAA); push(8'hBB); push(8'h00);
    exp_pay.push_back(9'h0AA); exp_pay.push_back(9'h1BB);
    expect_evt(1'b0, 2'd2, 8'd2);
    wait_idle(200);
    check("t2_err_code", err_code, 2'd2);
    check("t2_err_cnt", err_cnt, 8'd1);

    // Zero and oversize LEN.
    push(8'hA5); push(8'h00); push(8'hA5); push(8'h41);
    expect_evt(1'b0, 2'd1, 8'h00);
    expect_evt(1'b0, 2'd1, 8'h41);
    wait_idle(200);
    check("t3_err_code", err_code, 2'd1);
    check("t3_err_cnt", err_cnt, 8'd3);
    check("t3_drained", 32'(fifo_mem.size()), 32'd0);

    // Inter-byte timeout, then recovery.
    push(8'hA5); push(8'h02); push(8'h10);
    exp_pay.push_back(9'h010);
    expect_evt(1'b0, 2'd3, 8'd2);
    wait_idle(TO + 100);
    check("t4_err_cnt", err_cnt, 8'd4);
    push(8'hA5); push(8'h01); push(8'h55); push(8'h56);
    exp_pay.push_back(9'h155);
    expect_evt(1'b1, 2'd0, 8'd1);
    wait_idle(200);
    check("t4_ok_cnt", ok_cnt, 16'd2);
    check("t4_code_held", err_code, 2'd3);

    // Long core backpressure must not time the frame out.
    ready_mode = 2;
    push_frame1();
    wait_idle(2000);
    check("t5_ok_cnt", ok_cnt, 16'd3);
    check("t5_err_cnt", err_cnt, 8'd4);

    // Random traffic with FIFO gaps and random backpressure.
    ready_mode = 1;
    gate_mode  = 1;
    for (int b = 0; b < 4; b++) begin
      for (int f = 0; f < 10; f++) gen_frame();
      wait_idle(10000);
    end
    check("rand_ok_cnt", ok_cnt, ok_m);
    check("rand_err_cnt", err_cnt, err_m);

    // Reset mid-payload, then a clean frame.
    ready_mode = 0;
    gate_mode  = 0;
    repeat (4) @(negedge clk);
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h0E);
    exp_pay.push_back(9'h001); exp_pay.push_back(9'h002);
    exp_pay.push_back(9'h003); exp_pay.push_back(9'h104);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) fail_now("t6_no_payload");
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, frame_len}, 0);
    check("t6_rst_counters", {ok_cnt, err_cnt}, 0);
    fifo_mem.delete();
    exp_pay.delete();
    exp_evt.delete();
    ok_m = 16'd0; err_m = 8'd0; code_m = 2'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_frame1();
    wait_idle(200);
    check("t6_ok_cnt", ok_cnt, 16'd1);
    check("t6_err_cnt", err_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
